// File: rtl/ddc_pkg.sv
// ---------------------------------------------------------------------------
// ddc_pkg
// Shared widths for the digital down-converter mixer/decimator.
//   DATA_W : ADC and NCO sample width
//   OUT_W  : I/Q output width
//   CNT_W  : decimation ratio / sample counter width
//   MIX_W  : width of one mixed sample after the product rescale
//   ACC_W  : integrator width, wide enough for 2^CNT_W mixed samples
// ---------------------------------------------------------------------------
package ddc_pkg;

    localparam int DATA_W = 14;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 8;
    localparam int MIX_W  = 15;
    localparam int ACC_W  = MIX_W + CNT_W;

    // Integrator width for a given counter width.
    function automatic int accWidth(input int cntW);
        return MIX_W + cntW;
    endfunction

endpackage

// File: rtl/ddc_integ_dump.sv
// ---------------------------------------------------------------------------
// ddc_integ_dump
// Integrate-and-dump for one mixer rail (I or Q), followed by the output
// scaling (arithmetic right shift) and saturation to OUT_W bits.
//   i_clk     : clock, rising edge
//   i_resetN  : synchronous active-low reset
//   i_clken   : global clock enable
//   i_accept  : a mixed sample is present at the accumulate stage
//   i_last    : that sample is the last one of the current block
//   i_shift   : output right-shift used for this block
//   i_mix     : signed mixed sample
//   o_out     : registered, scaled and saturated block sum
// The dumped total is registered first and scaled/saturated one enabled
// edge later, which keeps the adder and the saturator in separate stages.
// ---------------------------------------------------------------------------
module ddc_integ_dump
    import ddc_pkg::*;
#(
    parameter int MIX_BITS = ddc_pkg::MIX_W,
    parameter int ACC_BITS = ddc_pkg::ACC_W,
    parameter int OUT_BITS = ddc_pkg::OUT_W
) (
    input  logic                       i_clk,
    input  logic                       i_resetN,
    input  logic                       i_clken,
    input  logic                       i_accept,
    input  logic                       i_last,
    input  logic [2:0]                 i_shift,
    input  logic signed [MIX_BITS-1:0] i_mix,
    output logic signed [OUT_BITS-1:0] o_out
);

    localparam logic signed [ACC_BITS-1:0] SAT_MAX =
        ACC_BITS'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [ACC_BITS-1:0] SAT_MIN =
        ACC_BITS'(-(64'sd1 <<< (OUT_BITS - 1)));

    logic signed [ACC_BITS-1:0] r_acc;
    logic signed [ACC_BITS-1:0] r_total;
    logic [2:0]                 r_shiftD;
    logic                       r_dumpV;
    logic signed [OUT_BITS-1:0] r_out;

    logic signed [ACC_BITS-1:0] w_total;
    logic signed [ACC_BITS-1:0] w_scaled;
    logic signed [OUT_BITS-1:0] w_sat;

    // The sample being dumped is included in the block total.
    assign w_total  = r_acc + ACC_BITS'(i_mix);
    assign w_scaled = r_total >>> r_shiftD;

    always_comb begin
        w_sat = OUT_BITS'(w_scaled);
        if (w_scaled > SAT_MAX) begin
            w_sat = OUT_BITS'(SAT_MAX);
        end else if (w_scaled < SAT_MIN) begin
            w_sat = OUT_BITS'(SAT_MIN);
        end
    end

    // Integrator; restarts from zero right after a dump.
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_acc <= '0;
        end else if (i_clken && i_accept) begin
            r_acc <= i_last ? '0 : w_total;
        end
    end

    // Capture the finished block total together with its own shift.
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_total  <= '0;
            r_shiftD <= '0;
            r_dumpV  <= 1'b0;
        end else if (i_clken) begin
            r_dumpV <= i_accept && i_last;
            if (i_accept && i_last) begin
                r_total  <= w_total;
                r_shiftD <= i_shift;
            end
        end
    end

    // Output register holds its value between dumps.
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_out <= '0;
        end else if (i_clken && r_dumpV) begin
            r_out <= w_sat;
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/ddc_mixer_decim.sv
// ---------------------------------------------------------------------------
// ddc_mixer_decim
// Complex mixer (ADC x NCO cos/sin) followed by an integrate-and-dump
// decimator with programmable ratio R and output right-shift.
//   clk         : clock, rising edge
//   reset_n     : synchronous active-low reset
//   clken       : global clock enable; all state holds while low
//   adc_i       : signed ADC sample
//   nco_cos_i   : signed NCO cosine
//   nco_sin_i   : signed NCO sine
//   nco_valid_i : qualifies the adc/cos/sin triple
//   decim_i     : decimation ratio R (0 and 1 both mean R=1)
//   shift_i     : output right-shift 0..7
//   i_o, q_o    : signed in-phase / quadrature outputs
//   out_valid   : one-cycle strobe for a new i_o/q_o
// Pipeline (enabled edges): input reg -> product reg -> accumulate/dump
// -> scaled/saturated output, so a block's strobe appears three enabled
// edges after its last sample is accepted.
// ---------------------------------------------------------------------------
module ddc_mixer_decim #(
    parameter int DATA_W = ddc_pkg::DATA_W,
    parameter int OUT_W  = ddc_pkg::OUT_W,
    parameter int CNT_W  = ddc_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clken,
    input  logic signed [DATA_W-1:0] adc_i,
    input  logic signed [DATA_W-1:0] nco_cos_i,
    input  logic signed [DATA_W-1:0] nco_sin_i,
    input  logic                     nco_valid_i,
    input  logic [CNT_W-1:0]         decim_i,
    input  logic [2:0]               shift_i,
    output logic signed [OUT_W-1:0]  i_o,
    output logic signed [OUT_W-1:0]  q_o,
    output logic                     out_valid
);

    import ddc_pkg::*;

    localparam int PROD_BITS = 2 * DATA_W;
    localparam int ACC_BITS  = accWidth(CNT_W);

    logic signed [DATA_W-1:0]    r_adc;
    logic signed [DATA_W-1:0]    r_cos;
    logic signed [DATA_W-1:0]    r_sin;
    logic [CNT_W-1:0]            r_decim1;
    logic [2:0]                  r_shift1;
    logic                        r_v1;

    logic signed [PROD_BITS-1:0] r_prodI;
    logic signed [PROD_BITS-1:0] r_prodQ;
    logic [CNT_W-1:0]            r_decim2;
    logic [2:0]                  r_shift2;
    logic                        r_v2;

    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            r_ratio;
    logic [2:0]                  r_shift;
    logic                        r_dumpV;
    logic                        r_outValid;

    logic signed [MIX_W-1:0]     w_mixI;
    logic signed [MIX_W-1:0]     w_mixQ;
    logic [CNT_W-1:0]            w_ratioIn;
    logic [CNT_W-1:0]            w_ratioEff;
    logic [2:0]                  w_shiftEff;
    logic                        w_accept;
    logic                        w_last;

    // Input register. decim_i/shift_i travel with each sample so that
    // samples already in flight ignore later changes of those inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_adc    <= '0;
            r_cos    <= '0;
            r_sin    <= '0;
            r_decim1 <= '0;
            r_shift1 <= '0;
            r_v1     <= 1'b0;
        end else if (clken) begin
            r_v1 <= nco_valid_i;
            if (nco_valid_i) begin
                r_adc    <= adc_i;
                r_cos    <= nco_cos_i;
                r_sin    <= nco_sin_i;
                r_decim1 <= decim_i;
                r_shift1 <= shift_i;
            end
        end
    end

    // Full-precision product register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prodI  <= '0;
            r_prodQ  <= '0;
            r_decim2 <= '0;
            r_shift2 <= '0;
            r_v2     <= 1'b0;
        end else if (clken) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_prodI  <= PROD_BITS'(r_adc) * PROD_BITS'(r_cos);
                r_prodQ  <= PROD_BITS'(r_adc) * PROD_BITS'(r_sin);
                r_decim2 <= r_decim1;
                r_shift2 <= r_shift1;
            end
        end
    end

    // Floor rescale of the products; Q is negated after rescaling.
    assign w_mixI = MIX_W'(r_prodI >>> (DATA_W - 1));
    assign w_mixQ = MIX_W'(-(r_prodQ >>> (DATA_W - 1)));

    // A block's ratio and shift come from its first sample; mid-block
    // samples use the values latched when the counter was at zero.
    assign w_ratioIn  = (r_decim2 <= CNT_W'(1)) ? CNT_W'(1) : r_decim2;
    assign w_ratioEff = (r_cnt == '0) ? w_ratioIn : r_ratio;
    assign w_shiftEff = (r_cnt == '0) ? r_shift2  : r_shift;
    assign w_accept   = clken && r_v2;
    assign w_last     = (r_cnt == (w_ratioEff - CNT_W'(1)));

    // Shared sample counter and per-block ratio/shift latch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_ratio <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            if (r_cnt == '0) begin
                r_ratio <= w_ratioIn;
                r_shift <= r_shift2;
            end
            r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
        end
    end

    // Strobe pipeline aligned with the output registers of the rails;
    // the strobe is forced low on every disabled edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dumpV    <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= clken && r_dumpV;
            if (clken) begin
                r_dumpV <= w_accept && w_last;
            end
        end
    end

    ddc_integ_dump #(
        .MIX_BITS (MIX_W),
        .ACC_BITS (ACC_BITS),
        .OUT_BITS (OUT_W)
    ) u_integI (
        .i_clk    (clk),
        .i_resetN (reset_n),
        .i_clken  (clken),
        .i_accept (w_accept),
        .i_last   (w_last),
        .i_shift  (w_shiftEff),
        .i_mix    (w_mixI),
        .o_out    (i_o)
    );

    ddc_integ_dump #(
        .MIX_BITS (MIX_W),
        .ACC_BITS (ACC_BITS),
        .OUT_BITS (OUT_W)
    ) u_integQ (
        .i_clk    (clk),
        .i_resetN (reset_n),
        .i_clken  (clken),
        .i_accept (w_accept),
        .i_last   (w_last),
        .i_shift  (w_shiftEff),
        .i_mix    (w_mixQ),
        .o_out    (q_o)
    );

    assign out_valid = r_outValid;

endmodule

// File: tb/tb_ddc_mixer_decim.sv
// ---------------------------------------------------------------------------
// tb_ddc_mixer_decim
// Directed bench for ddc_mixer_decim: hand-computed block sums, latency,
// saturation, floor rounding, ratio change, mid-block reset and a
// clock-enable / valid toggling run checked against a small mixer model.
// ---------------------------------------------------------------------------
module tb_ddc_mixer_decim;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               clken;
    logic signed [13:0] adc_i;
    logic signed [13:0] nco_cos_i;
    logic signed [13:0] nco_sin_i;
    logic               nco_valid_i;
    logic [7:0]         decim_i;
    logic [2:0]         shift_i;
    logic signed [15:0] i_o;
    logic signed [15:0] q_o;
    logic               out_valid;

    int errors    = 0;
    int checks    = 0;
    int cycCount  = 0;
    int lastAcc   = 0;
    logic monEn;

    int strI[$];
    int strQ[$];
    int strCyc[$];

    always #5 clk = ~clk;

    ddc_mixer_decim dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clken       (clken),
        .adc_i       (adc_i),
        .nco_cos_i   (nco_cos_i),
        .nco_sin_i   (nco_sin_i),
        .nco_valid_i (nco_valid_i),
        .decim_i     (decim_i),
        .shift_i     (shift_i),
        .i_o         (i_o),
        .q_o         (q_o),
        .out_valid   (out_valid)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] got,
                               input logic signed [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; remembers the edge index of an accept.
    task automatic applyStimulus(input int adc, input int cosV, input int sinV,
                                 input logic valid, input logic en);
        logic [31:0] a;
        logic [31:0] c;
        logic [31:0] s;
        a = adc;
        c = cosV;
        s = sinV;
        adc_i       = a[13:0];
        nco_cos_i   = c[13:0];
        nco_sin_i   = s[13:0];
        nco_valid_i = valid;
        clken       = en;
        @(posedge clk);
        #1;
        if (valid && en && reset_n) lastAcc = cycCount;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic clearStrobes();
        strI.delete();
        strQ.delete();
        strCyc.delete();
    endtask

    function automatic int getI(input int k);
        return (strI.size() > k) ? strI[k] : -999999;
    endfunction

    function automatic int getQ(input int k);
        return (strQ.size() > k) ? strQ[k] : -999999;
    endfunction

    function automatic int getCyc(input int k);
        return (strCyc.size() > k) ? strCyc[k] : -999999;
    endfunction

    function automatic int mixI(input int a, input int c);
        longint p;
        p = longint'(a) * longint'(c);
        return int'(p >>> 13);
    endfunction

    function automatic int mixQ(input int a, input int s);
        longint p;
        p = longint'(a) * longint'(s);
        return -int'(p >>> 13);
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Records every strobe and checks the strobe is low after disabled edges.
    always @(posedge clk) begin
        monEn = clken;
        cycCount = cycCount + 1;
        #1;
        if (out_valid === 1'b1) begin
            strI.push_back(int'(i_o));
            strQ.push_back(int'(q_o));
            strCyc.push_back(cycCount);
        end
        if (monEn === 1'b0) checkOutput("strobeWhileOff", out_valid, 0);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int acc0, acc1, acc2;
        int sumI, sumQ, nInBlk, accepted, iter;
        int expI[$];
        int expQ[$];

        reset_n     = 1'b0;
        clken       = 1'b1;
        adc_i       = '0;
        nco_cos_i   = '0;
        nco_sin_i   = '0;
        nco_valid_i = 1'b0;
        decim_i     = 8'd4;
        shift_i     = 3'd0;

        // Reset state.
        idleCycles(3);
        checkOutput("rstI", i_o, 0);
        checkOutput("rstQ", q_o, 0);
        checkOutput("rstValid", out_valid, 0);
        reset_n = 1'b1;
        idleCycles(2);

        // R=4, 8 samples of 1000*8191 -> mix 999, block sum 3996.
        clearStrobes();
        decim_i = 8'd4;
        shift_i = 3'd0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1000, 8191, 0, 1'b1, 1'b1);
            if (k == 3) acc0 = lastAcc;
            if (k == 7) acc1 = lastAcc;
        end
        idleCycles(6);
        checkOutput("t1Count", strI.size(), 2);
        checkOutput("t1I0", getI(0), 3996);
        checkOutput("t1I1", getI(1), 3996);
        checkOutput("t1Q0", getQ(0), 0);
        checkOutput("t1Lat0", getCyc(0) - acc0, 3);
        checkOutput("t1Lat1", getCyc(1) - acc1, 3);
        checkOutput("t1HoldI", i_o, 3996);
        checkOutput("t1HoldValid", out_valid, 0);

        // R=255 of full-scale negative inputs saturates both rails.
        clearStrobes();
        decim_i = 8'd255;
        for (int k = 0; k < 255; k++) applyStimulus(-8192, -8192, -8192, 1'b1, 1'b1);
        idleCycles(6);
        checkOutput("t2Count", strI.size(), 1);
        checkOutput("t2SatI", getI(0), 32767);
        checkOutput("t2SatQ", getQ(0), -32768);

        // Floor rounding: -1*1 >>> 13 = -1, two samples -> -2, shift 1 -> -1.
        clearStrobes();
        decim_i = 8'd2;
        shift_i = 3'd0;
        applyStimulus(-1, 1, 0, 1'b1, 1'b1);
        applyStimulus(-1, 1, 0, 1'b1, 1'b1);
        shift_i = 3'd1;
        applyStimulus(-1, 1, 0, 1'b1, 1'b1);
        applyStimulus(-1, 1, 0, 1'b1, 1'b1);
        idleCycles(6);
        checkOutput("t3Count", strI.size(), 2);
        checkOutput("t3FloorI", getI(0), -2);
        checkOutput("t3ShiftI", getI(1), -1);
        checkOutput("t3Q", getQ(1), 0);

        // Ratio 4 -> 2 after the first sample: spans of 4, then 2, then 2.
        clearStrobes();
        decim_i = 8'd4;
        shift_i = 3'd0;
        applyStimulus(1000, 8191, 0, 1'b1, 1'b1);
        decim_i = 8'd2;
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1000, 8191, 0, 1'b1, 1'b1);
            if (k == 3) acc0 = lastAcc;
            if (k == 5) acc1 = lastAcc;
            if (k == 7) acc2 = lastAcc;
        end
        idleCycles(6);
        checkOutput("t4Count", strI.size(), 3);
        checkOutput("t4I0", getI(0), 3996);
        checkOutput("t4I1", getI(1), 1998);
        checkOutput("t4I2", getI(2), 1998);
        checkOutput("t4Lat0", getCyc(0) - acc0, 3);
        checkOutput("t4Lat1", getCyc(1) - acc1, 3);
        checkOutput("t4Lat2", getCyc(2) - acc2, 3);

        // Mid-block reset after 2 of 4 samples; then a fresh block of 4.
        decim_i = 8'd4;
        applyStimulus(1000, 8191, 0, 1'b1, 1'b1);
        applyStimulus(1000, 8191, 0, 1'b1, 1'b1);
        reset_n = 1'b0;
        applyStimulus(1000, 8191, 0, 1'b1, 1'b1);
        reset_n = 1'b1;
        checkOutput("t5RstI", i_o, 0);
        checkOutput("t5RstQ", q_o, 0);
        checkOutput("t5RstValid", out_valid, 0);
        clearStrobes();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2000, 8191, 0, 1'b1, 1'b1);
            if (k == 3) acc0 = lastAcc;
        end
        idleCycles(6);
        checkOutput("t5Count", strI.size(), 1);
        checkOutput("t5I", getI(0), 7996);
        checkOutput("t5Lat", getCyc(0) - acc0, 3);

        // Toggling clken / nco_valid_i with R=3 against the mixer model.
        clearStrobes();
        decim_i  = 8'd3;
        shift_i  = 3'd0;
        sumI     = 0;
        sumQ     = 0;
        nInBlk   = 0;
        accepted = 0;
        iter     = 0;
        while (accepted < 30 && iter < 3000) begin
            int a, c, s;
            logic en, v;
            en = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 1) != 0);
            a  = int'($urandom_range(0, 16383)) - 8192;
            c  = int'($urandom_range(0, 16383)) - 8192;
            s  = int'($urandom_range(0, 16383)) - 8192;
            applyStimulus(a, c, s, v, en);
            if (en && v) begin
                sumI = sumI + mixI(a, c);
                sumQ = sumQ + mixQ(a, s);
                nInBlk = nInBlk + 1;
                accepted = accepted + 1;
                if (nInBlk == 3) begin
                    expI.push_back(sat16(sumI));
                    expQ.push_back(sat16(sumQ));
                    sumI = 0;
                    sumQ = 0;
                    nInBlk = 0;
                end
            end
            iter = iter + 1;
        end
        checkOutput("t6Accepted", accepted, 30);
        idleCycles(8);
        checkOutput("t6Count", strI.size(), expI.size());
        for (int k = 0; k < expI.size(); k++) begin
            checkOutput("t6I", getI(k), expI[k]);
            checkOutput("t6Q", getQ(k), expQ[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddc_mixer_decim.md
DDC_MIXER_DECIM -- requirements
Module: ddc_mixer_decim

Interface
REQ-001 SHALL have parameter DATA_W, default 14, ADC and NCO sample width.
REQ-002 SHALL have parameter OUT_W, default 16, I/Q output width.
REQ-003 SHALL have parameter CNT_W, default 8, decimation-ratio width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port clken  input  1  global clock enable.
REQ-007 SHALL have port adc_i  input  DATA_W  signed ADC sample.
REQ-008 SHALL have port nco_cos_i  input  DATA_W  signed NCO cosine (fcos_o).
REQ-009 SHALL have port nco_sin_i  input  DATA_W  signed NCO sine (fsin_o).
REQ-010 SHALL have port nco_valid_i  input  1  NCO out_valid; qualifies the adc_i/nco_*_i triple.
REQ-011 SHALL have port decim_i  input  CNT_W  decimation ratio R; values 0 and 1 both mean R=1.
REQ-012 SHALL have port shift_i  input  3  output right-shift, 0..7.
REQ-013 SHALL have port i_o  output  OUT_W  signed in-phase output.
REQ-014 SHALL have port q_o  output  OUT_W  signed quadrature output.
REQ-015 SHALL have port out_valid  output  1  one-cycle strobe marking a new i_o/q_o.

Function
REQ-016 SHALL accept a sample on every edge where clken=1 and nco_valid_i=1; all other edges accept nothing.
REQ-017 SHALL compute, per accepted sample, mix_i = (adc*cos) >>> (DATA_W-1) and mix_q = -((adc*sin) >>> (DATA_W-1)), full-precision 2*DATA_W-bit signed product, arithmetic shift (floor), 15-bit signed result.
REQ-018 SHALL pipeline the mixer as: input register (edge 1), product register (edge 2), accumulate/dump (edge 3).
REQ-019 SHALL accumulate mix_i and mix_q into ACC_W = 15+CNT_W-bit signed accumulators, with a sample counter running 0..R-1.
REQ-020 SHALL latch decim_i and shift_i only when the counter is 0 and a sample enters the accumulate stage, so each block uses one R and one shift.
REQ-021 SHALL, on the R-th sample of a block, form total = acc + mix, load the accumulator with 0, and reset the counter to 0 (dump).
REQ-022 SHALL on dump register i_o/q_o = total >>> shift, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-023 SHALL assert out_valid for exactly one cycle, on the edge 3 clocks after the edge accepting the block's last sample.
REQ-024 SHALL hold i_o/q_o between dumps.
REQ-025 SHALL, while clken=0, hold every register except out_valid, which it drives 0.
REQ-026 SHALL with R=1 dump every sample, giving one out_valid per accepted sample.
REQ-027 SHALL propagate samples already in the pipeline unaffected by later changes of decim_i/shift_i.

Reset
REQ-028 SHALL, on an edge with reset_n=0 and regardless of clken, clear pipeline registers, accumulators, counter, i_o, q_o and out_valid to 0.
REQ-029 SHALL discard a partial block on mid-block reset; the first block after reset starts at the first sample accepted after release, using the then-current decim_i/shift_i.

Structure
REQ-030 SHALL take DATA_W, OUT_W, CNT_W, MIX_W=15 and ACC_W from shared package ddc_pkg.
REQ-031 SHALL place integrate-and-dump, scaling and saturation in sub-module ddc_integ_dump, instanced once for I and once for Q, sharing the counter in the top level.

Verification
REQ-032 SHALL verify: adc=1000, cos=8191, sin=0, R=4, shift=0, 8 samples -> two out_valid strobes, i_o=3996, q_o=0.
REQ-033 SHALL verify: adc=-8192, cos=-8192, sin=-8192, R=255, shift=0 -> i_o=32767, q_o=-32768 (saturated).
REQ-034 SHALL verify: adc=-1, cos=1, R=2, shift=0 -> i_o=-2 (floor rounding); with shift=1 -> i_o=-1.
REQ-035 SHALL verify: decim_i changed 4->2 after the first sample of a block -> that block spans 4 samples, the following blocks span 2.
REQ-036 SHALL verify: nco_valid_i and clken toggled pseudo-randomly, R=3 -> one strobe per 3 accepted samples, out_valid never 1 while clken=0, and the sums match the model.
REQ-037 SHALL verify: reset_n pulsed low for one cycle after 2 of 4 samples -> outputs 0 the next edge, and the first strobe after release comes after 4 new samples.
